color_centroid: RTL and testbench

COLOR_CENTROID -- requirements
Module: color_centroid

---
 rtl/color_centroid.sv | 265 ++++++++++++++++++++++++++
 tb/tb_color_centroid.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid.sv
// color_centroid: classifies YCrCb pixels into four threshold-defined colors,
// accumulates per-color count / sum_x / sum_y across a frame and, on frame end,
// runs a shared restoring divider to produce one mean position per color.
// Optional build macro: CENTROID_PIXEL_CLASS_EN exposes the registered
// per-pixel classification on pixel_class (tied to 0 otherwise).

module color_match (
    input  logic [9:0]  lum,
    input  logic [9:0]  cr,
    input  logic [9:0]  cb,
    input  logic [59:0] thresh,
    output logic        hit
);
    // inclusive unsigned window per channel; an inverted window can never match
    assign hit = (lum >= thresh[49:40]) && (lum <= thresh[59:50]) &&
                 (cr  >= thresh[29:20]) && (cr  <= thresh[39:30]) &&
                 (cb  >= thresh[9:0])   && (cb  <= thresh[19:10]);
endmodule

module color_centroid #(
    parameter int MIN_COUNT = 64,
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pixel_valid,
    input  logic [9:0]             pix_lum,
    input  logic [9:0]             pix_cr,
    input  logic [9:0]             pix_cb,
    input  logic [X_WIDTH-1:0]     pix_x,
    input  logic [Y_WIDTH-1:0]     pix_y,
    input  logic                   frame_end,
    input  logic [59:0]            thresh_green,
    input  logic [59:0]            thresh_orange,
    input  logic [59:0]            thresh_pink,
    input  logic [59:0]            thresh_blue,
    output logic [4*X_WIDTH-1:0]   centroid_x,
    output logic [4*Y_WIDTH-1:0]   centroid_y,
    output logic [3:0]             found,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic [2:0]             pixel_class
);
    localparam int NUM_COLORS = 4;
    localparam int QW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int SW = 28 + QW;              // room for count shifted by QW-1
    localparam int BW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    typedef struct packed {
        logic               hit;
        logic [1:0]         color;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic               fe;
    } cls_t;

    logic [NUM_COLORS-1:0][59:0] thr;
    logic [NUM_COLORS-1:0]       match;
    logic                        hit;
    logic [1:0]                  color;
    cls_t                        cls;

    assign thr = {thresh_blue, thresh_pink, thresh_orange, thresh_green};

    for (genvar c = 0; c < NUM_COLORS; c++) begin : g_match
        color_match u_match (
            .lum    (pix_lum),
            .cr     (pix_cr),
            .cb     (pix_cb),
            .thresh (thr[c]),
            .hit    (match[c])
        );
    end

    // lowest color index wins when windows overlap
    always_comb begin
        hit   = pixel_valid && (|match);
        color = 2'd0;
        for (int c = NUM_COLORS - 1; c >= 0; c--)
            if (match[c]) color = 2'(c);
    end

    // one-cycle classification stage; frame_end rides along so it stays aligned
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cls <= '0;
        end else begin
            cls.hit   <= hit;
            cls.color <= hit ? color : 2'd0;
            cls.x     <= pix_x;
            cls.y     <= pix_y;
            cls.fe    <= frame_end;
        end
    end

`ifdef CENTROID_PIXEL_CLASS_EN
    assign pixel_class = {cls.hit, cls.color};
`else
    assign pixel_class = 3'd0;
`endif

    // ---------------- accumulators ----------------
    logic [NUM_COLORS-1:0][18:0] acc_cnt, snap_cnt, nxt_cnt;
    logic [NUM_COLORS-1:0][27:0] acc_sx, acc_sy, snap_sx, snap_sy, nxt_sx, nxt_sy;
    state_t                      state, state_nxt;

    // saturating add of the classified pixel into its color's accumulators
    always_comb begin : acc_next
        logic        inc;
        logic [19:0] t_cnt;
        logic [28:0] t_sx;
        logic [28:0] t_sy;
        inc     = 1'b0;
        t_cnt   = '0;
        t_sx    = '0;
        t_sy    = '0;
        nxt_cnt = acc_cnt;
        nxt_sx  = acc_sx;
        nxt_sy  = acc_sy;
        for (int c = 0; c < NUM_COLORS; c++) begin
            inc        = cls.hit && (cls.color == 2'(c));
            t_cnt      = {1'b0, acc_cnt[c]} + 20'(inc);
            t_sx       = {1'b0, acc_sx[c]} + (inc ? 29'(cls.x) : 29'd0);
            t_sy       = {1'b0, acc_sy[c]} + (inc ? 29'(cls.y) : 29'd0);
            nxt_cnt[c] = t_cnt[19] ? '1 : t_cnt[18:0];
            nxt_sx[c]  = t_sx[28]  ? '1 : t_sx[27:0];
            nxt_sy[c]  = t_sy[28]  ? '1 : t_sy[27:0];
        end
    end

    // frame end: snapshot (including the final pixel) only when the divider is free;
    // live accumulators always restart from zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_cnt  <= '0;
            acc_sx   <= '0;
            acc_sy   <= '0;
            snap_cnt <= '0;
            snap_sx  <= '0;
            snap_sy  <= '0;
        end else if (cls.fe) begin
            acc_cnt <= '0;
            acc_sx  <= '0;
            acc_sy  <= '0;
            if (state == IDLE) begin
                snap_cnt <= nxt_cnt;
                snap_sx  <= nxt_sx;
                snap_sy  <= nxt_sy;
            end
        end else begin
            acc_cnt <= nxt_cnt;
            acc_sx  <= nxt_sx;
            acc_sy  <= nxt_sy;
        end
    end

    // ---------------- control ----------------
    logic [2:0]    div_idx, idx_nxt;
    logic [BW-1:0] div_bit;
    logic [SW-1:0] div_rem, rem_nxt, div_sub;
    logic [QW-1:0] div_q, q_nxt;
    logic          take, div_end, div_last;

    assign div_end  = (div_bit == '0);
    assign div_last = div_end && (div_idx == 3'd7);
    assign busy     = (state != IDLE);

    // state register plus the overrun pulse for frames that arrive while busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= cls.fe && (state != IDLE);
        end
    end

    // next-state: one LOAD cycle, eight back-to-back divisions, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cls.fe) state_nxt = LOAD;
            LOAD:    state_nxt = DIV;
            DIV:     if (div_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- restoring divider ----------------
    // division idx: color = idx[2:1], axis = idx[0] (0 = x, 1 = y)
    assign idx_nxt = div_idx + 3'd1;

    // one quotient bit per cycle: subtract count << bit when it fits
    always_comb begin
        div_sub = SW'(snap_cnt[div_idx[2:1]]) << div_bit;
        take    = (div_rem >= div_sub);
        rem_nxt = take ? (div_rem - div_sub) : div_rem;
        q_nxt   = div_q;
        if (take) q_nxt[div_bit] = 1'b1;
    end

    logic [NUM_COLORS-1:0][X_WIDTH-1:0] res_x;
    logic [NUM_COLORS-1:0][Y_WIDTH-1:0] res_y;

    // divider sequencing and result publication on the last quotient bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_idx      <= '0;
            div_bit      <= '0;
            div_rem      <= '0;
            div_q        <= '0;
            res_x        <= '0;
            res_y        <= '0;
            centroid_x   <= '0;
            centroid_y   <= '0;
            found        <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (state == LOAD) begin
                div_idx <= '0;
                div_bit <= BW'(X_WIDTH - 1);
                div_rem <= SW'(snap_sx[0]);
                div_q   <= '0;
            end else if (state == DIV) begin
                if (div_end) begin
                    if (div_idx[0]) res_y[div_idx[2:1]] <= q_nxt[Y_WIDTH-1:0];
                    else            res_x[div_idx[2:1]] <= q_nxt[X_WIDTH-1:0];
                    div_idx <= idx_nxt;
                    div_bit <= idx_nxt[0] ? BW'(Y_WIDTH - 1) : BW'(X_WIDTH - 1);
                    div_rem <= idx_nxt[0] ? SW'(snap_sy[idx_nxt[2:1]])
                                          : SW'(snap_sx[idx_nxt[2:1]]);
                    div_q   <= '0;
                end else begin
                    div_bit <= div_bit - BW'(1);
                    div_rem <= rem_nxt;
                    div_q   <= q_nxt;
                end
                if (div_last) begin
                    result_valid <= 1'b1;
                    // blue y is still in flight this cycle, so take it straight from q_nxt;
                    // colors under MIN_COUNT (incl. count 0) report zeros
                    for (int c = 0; c < NUM_COLORS; c++) begin
                        if (32'(snap_cnt[c]) >= 32'(MIN_COUNT)) begin
                            found[c] <= 1'b1;
                            centroid_x[c*X_WIDTH +: X_WIDTH] <= res_x[c];
                            centroid_y[c*Y_WIDTH +: Y_WIDTH] <=
                                (c == NUM_COLORS - 1) ? q_nxt[Y_WIDTH-1:0] : res_y[c];
                        end else begin
                            found[c] <= 1'b0;
                            centroid_x[c*X_WIDTH +: X_WIDTH] <= '0;
                            centroid_y[c*Y_WIDTH +: Y_WIDTH] <= '0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_color_centroid.sv
// Testbench for color_centroid: directed frames plus randomized frames checked
// against a per-frame reference (first-matching-color classification, plain
// integer sums and floor division).
module tb_color_centroid;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int MINC = 64;
    localparam int LAT = 2 + 4 * (XW + YW);

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            pixel_valid = 1'b0;
    logic [9:0]      pix_lum = '0, pix_cr = '0, pix_cb = '0;
    logic [XW-1:0]   pix_x = '0;
    logic [YW-1:0]   pix_y = '0;
    logic            frame_end = 1'b0;
    logic [59:0]     thresh_green = '0, thresh_orange = '0, thresh_pink = '0, thresh_blue = '0;
    logic [4*XW-1:0] centroid_x;
    logic [4*YW-1:0] centroid_y;
    logic [3:0]      found;
    logic            result_valid, busy, overrun;
    logic [2:0]      pixel_class;

    color_centroid dut (
        .clock(clock), .reset(reset), .pixel_valid(pixel_valid),
        .pix_lum(pix_lum), .pix_cr(pix_cr), .pix_cb(pix_cb),
        .pix_x(pix_x), .pix_y(pix_y), .frame_end(frame_end),
        .thresh_green(thresh_green), .thresh_orange(thresh_orange),
        .thresh_pink(thresh_pink), .thresh_blue(thresh_blue),
        .centroid_x(centroid_x), .centroid_y(centroid_y), .found(found),
        .result_valid(result_valid), .busy(busy), .overrun(overrun),
        .pixel_class(pixel_class)
    );

    always #5 clock = ~clock;

    int th_lmin[4], th_lmax[4], th_rmin[4], th_rmax[4], th_bmin[4], th_bmax[4];
    longint m_cnt[4], m_sx[4], m_sy[4];
    logic [3:0]      e_found;
    logic [4*XW-1:0] e_cx;
    logic [4*YW-1:0] e_cy;
    logic [3:0]      g_found;
    logic [4*XW-1:0] g_cx;
    logic [4*YW-1:0] g_cy;
    int total = 0, passed = 0, failed = 0;

`ifdef CENTROID_PIXEL_CLASS_EN
    localparam logic [2:0] PINK_CLASS = 3'b110;
`else
    localparam logic [2:0] PINK_CLASS = 3'b000;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] pack(input int c);
        return {10'(th_lmax[c]), 10'(th_lmin[c]), 10'(th_rmax[c]),
                10'(th_rmin[c]), 10'(th_bmax[c]), 10'(th_bmin[c])};
    endfunction

    task automatic set_thr(input int c, input int lmin, lmax, rmin, rmax, bmin, bmax);
        th_lmin[c] = lmin; th_lmax[c] = lmax;
        th_rmin[c] = rmin; th_rmax[c] = rmax;
        th_bmin[c] = bmin; th_bmax[c] = bmax;
        thresh_green  = pack(0);
        thresh_orange = pack(1);
        thresh_pink   = pack(2);
        thresh_blue   = pack(3);
    endtask

    task automatic disable_all();
        for (int c = 0; c < 4; c++) set_thr(c, 1023, 0, 1023, 0, 1023, 0);
    endtask

    function automatic int classify(input int l, r, b);
        for (int c = 0; c < 4; c++)
            if (l >= th_lmin[c] && l <= th_lmax[c] && r >= th_rmin[c] && r <= th_rmax[c] &&
                b >= th_bmin[c] && b <= th_bmax[c]) return c;
        return -1;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_sx[c] = 0; m_sy[c] = 0; end
    endtask

    task automatic close_model();
        e_found = '0; e_cx = '0; e_cy = '0;
        for (int c = 0; c < 4; c++)
            if (m_cnt[c] >= MINC) begin
                e_found[c] = 1'b1;
                e_cx[c*XW +: XW] = XW'(m_sx[c] / m_cnt[c]);
                e_cy[c*YW +: YW] = YW'(m_sy[c] / m_cnt[c]);
            end
        clear_model();
    endtask

    // drive one cycle of input; the model follows the frame the pixel belongs to
    task automatic send(input bit v, input int l, r, b, x, y, input bit fe);
        int c;
        pixel_valid = v; pix_lum = 10'(l); pix_cr = 10'(r); pix_cb = 10'(b);
        pix_x = XW'(x); pix_y = YW'(y); frame_end = fe;
        if (v) begin
            c = classify(l, r, b);
            if (c >= 0) begin m_cnt[c]++; m_sx[c] += x; m_sy[c] += y; end
        end
        if (fe) close_model();
        @(negedge clock);
        pixel_valid = 1'b0; frame_end = 1'b0;
    endtask

    // called right after the frame_end cycle: result must appear LAT cycles later
    task automatic expect_result(input string tag);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 300) begin @(negedge clock); n++; end
        g_found = found; g_cx = centroid_x; g_cy = centroid_y;
        check({tag, ".latency"}, n, LAT);
        check({tag, ".found"}, found, e_found);
        check({tag, ".cx"}, centroid_x, e_cx);
        check({tag, ".cy"}, centroid_y, e_cy);
        check({tag, ".busy_done"}, busy, 1);
        @(negedge clock);
        check({tag, ".rv_pulse"}, result_valid, 0);
        check({tag, ".idle"}, busy, 0);
        check({tag, ".hold_cx"}, centroid_x, e_cx);
    endtask

    task automatic rand_thr(input int c);
        int lmin, rmin, bmin;
        lmin = $urandom_range(0, 700); rmin = $urandom_range(0, 700); bmin = $urandom_range(0, 700);
        set_thr(c, lmin, lmin + $urandom_range(50, 300), rmin, rmin + $urandom_range(50, 300),
                bmin, bmin + $urandom_range(50, 300));
    endtask

    initial begin
        int rv_n, ov_n, rv_at;
        logic [3:0] o_found;
        logic [4*XW-1:0] o_cx;
        logic [4*YW-1:0] o_cy;
        clear_model();
        disable_all();

        // reset state
        #3;
        check("rst.cx", centroid_x, 0);
        check("rst.cy", centroid_y, 0);
        check("rst.found", found, 0);
        check("rst.flags", {result_valid, busy, overrun}, 0);
        check("rst.class", pixel_class, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // green row frame, plus one pink pixel for the class output
        set_thr(0, 100, 300, 200, 400, 200, 400);
        set_thr(2, 500, 600, 600, 700, 100, 200);
        send(1, 550, 650, 150, 5, 5, 0);
        check("class.pink", pixel_class, PINK_CLASS);
        send(1, 900, 900, 900, 5, 5, 0);
        check("class.none", pixel_class, 0);
        for (int i = 0; i < 100; i++) send(1, 200, 300, 300, 10 + i, 50, 0);
        send(0, 0, 0, 0, 0, 0, 1);
        expect_result("green");
        check("green.const_found", g_found, 4'b0001);
        check("green.const_x", g_cx[XW-1:0], 59);
        check("green.const_y", g_cy[YW-1:0], 50);

        // overlap goes to green; 63 blue is one short
        disable_all();
        set_thr(0, 100, 300, 200, 400, 200, 400);
        set_thr(3, 250, 500, 350, 600, 350, 600);
        send(1, 260, 380, 380, 30, 30, 0);
        for (int i = 0; i < 63; i++) send(1, 450, 500, 500, 40 + i, 60, 0);
        send(0, 0, 0, 0, 0, 0, 1);
        expect_result("overlap");
        check("overlap.const_found", g_found, 4'b0000);

        // final pixel rides on the frame_end cycle and reaches MIN_COUNT
        disable_all();
        set_thr(0, 100, 300, 200, 400, 200, 400);
        for (int i = 0; i < 63; i++) send(1, 200, 300, 300, 639, 479, 0);
        send(1, 200, 300, 300, 639, 479, 1);
        expect_result("edge");
        check("edge.const", {g_found, 6'(0), g_cx[XW-1:0], g_cy[YW-1:0]},
              {4'b0001, 6'(0), 10'd639, 9'd479});

        // randomized frames, thresholds changed mid-frame
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 4; c++) rand_thr(c);
            if (f == 1) set_thr(3, 800, 100, 0, 1023, 0, 1023);
            for (int i = 0; i < 400; i++) begin
                int c, l, r, b;
                bit v;
                if (i == 200) rand_thr($urandom_range(0, 2));
                v = ($urandom_range(0, 9) != 0);
                c = $urandom_range(0, 3);
                if ($urandom_range(0, 9) < 7 && th_lmin[c] <= th_lmax[c]) begin
                    l = $urandom_range(th_lmin[c], th_lmax[c] > 1023 ? 1023 : th_lmax[c]);
                    r = $urandom_range(th_rmin[c], th_rmax[c] > 1023 ? 1023 : th_rmax[c]);
                    b = $urandom_range(th_bmin[c], th_bmax[c] > 1023 ? 1023 : th_bmax[c]);
                end else begin
                    l = $urandom_range(0, 1023); r = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
                end
                send(v, l, r, b, $urandom_range(0, 639), $urandom_range(0, 479), i == 399);
            end
            expect_result($sformatf("rand%0d", f));
        end

        // overrun: second frame_end 30 cycles into the divide is dropped
        disable_all();
        set_thr(0, 100, 300, 200, 400, 200, 400);
        for (int i = 0; i < 70; i++) send(1, 200, 300, 300, 100 + (i % 7), 20 + (i % 3), 0);
        send(0, 0, 0, 0, 0, 0, 1);
        rv_n = 0; ov_n = 0; rv_at = -1;
        o_found = '0; o_cx = '0; o_cy = '0;
        for (int n = 1; n <= 120; n++) begin
            if (n >= 5 && n < 25) begin
                pixel_valid = 1'b1; pix_lum = 10'd200; pix_cr = 10'd300; pix_cb = 10'd300;
                pix_x = XW'(600); pix_y = YW'(400);
            end
            if (n == 30) frame_end = 1'b1;
            @(negedge clock);
            pixel_valid = 1'b0; frame_end = 1'b0;
            if (result_valid === 1'b1) begin
                rv_n++; rv_at = n; o_found = found; o_cx = centroid_x; o_cy = centroid_y;
            end
            if (overrun === 1'b1) ov_n++;
        end
        check("ovr.rv_count", rv_n, 1);
        check("ovr.rv_at", rv_at, LAT);
        check("ovr.ov_count", ov_n, 1);
        check("ovr.found", o_found, e_found);
        check("ovr.cx", o_cx, e_cx);
        check("ovr.cy", o_cy, e_cy);
        for (int i = 0; i < 66; i++) send(1, 200, 300, 300, 300 + (i % 4), 200, 0);
        send(0, 0, 0, 0, 0, 0, 1);
        expect_result("post_ovr");

        // reset in the middle of the divide
        for (int i = 0; i < 70; i++) send(1, 200, 300, 300, 400, 300, 0);
        send(0, 0, 0, 0, 0, 0, 1);
        repeat (42) @(negedge clock);
        check("rstdiv.busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("rstdiv.cx", centroid_x, 0);
        check("rstdiv.cy", centroid_y, 0);
        check("rstdiv.found", found, 0);
        check("rstdiv.flags", {result_valid, busy, overrun, pixel_class}, 0);
        @(negedge clock);
        reset = 1'b1;
        clear_model();
        rv_n = 0;
        repeat (120) begin @(negedge clock); if (result_valid === 1'b1) rv_n++; end
        check("rstdiv.no_rv", rv_n, 0);
        check("rstdiv.found_hold", found, 0);
        for (int i = 0; i < 80; i++) send(1, 200, 300, 300, 50 + i, 100 + (i % 2), 0);
        send(0, 0, 0, 0, 0, 0, 1);
        expect_result("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
